// File: rtl/edp_ar.sv
// AR/ARX register slice of the EDP: per-field AR load/clear, ARX load,
// one-bit left shift of AR or AR!ARX, carry-36 delay and sticky strobe-conflict flag.
module edp_ar (
  input  logic        clk,
  input  logic        reset,
  input  logic        CTL_ARL_SEL,
  input  logic        CTL_ARR_SEL,
  input  logic        CTL_AR00to08load,
  input  logic        CTL_AR09to17load,
  input  logic        CTL_ARRload,
  input  logic        CTL_AR00to11clr,
  input  logic        CTL_AR12to17clr,
  input  logic        CTL_ARRclr,
  input  logic        CRAM_ARXload,
  input  logic        CRAM_ARshift,
  input  logic        ADXcarry36,
  input  logic        ADlong,
  input  logic [0:35] EDP_AD,
  input  logic [0:35] EDP_ADX,
  input  logic [0:35] MBOX_CACHE_DATA,
  output logic [0:35] EDP_AR,
  output logic [0:35] EDP_ARX,
  output logic        EDP_carry36Q,
  output logic        EDP_ctlConflict
);

  logic [0:35] ar_q, ar_d;
  logic [0:35] arx_q, arx_d;
  logic        carry36_q;
  logic        conflict_q, conflict_d;

  logic [0:17] left_src_s;
  logic [0:17] right_src_s;
  logic        ar_strobe_s;
  logic        shift_en_s;
  logic        long_arx_collide_s;

  // Source selection and strobe decode
  always_comb begin
    left_src_s         = CTL_ARL_SEL ? MBOX_CACHE_DATA[0:17]  : EDP_AD[0:17];
    right_src_s        = CTL_ARR_SEL ? MBOX_CACHE_DATA[18:35] : EDP_AD[18:35];
    ar_strobe_s        = CTL_AR00to08load | CTL_AR09to17load | CTL_ARRload |
                         CTL_AR00to11clr  | CTL_AR12to17clr  | CTL_ARRclr;
    shift_en_s         = CRAM_ARshift & ~ar_strobe_s;
    // A long shift and an ARX load fight over ARX; the shift wins but it is flagged.
    long_arx_collide_s = shift_en_s & ADlong & CRAM_ARXload;
  end

  // AR next state: shift when unopposed, otherwise per-field clear-over-load
  always_comb begin
    ar_d = ar_q;
    if (shift_en_s) begin
      ar_d = {ar_q[1:35], (ADlong ? arx_q[0] : ADXcarry36)};
    end else begin
      if (CTL_AR00to11clr) begin
        ar_d[0:8] = 9'd0;
      end else if (CTL_AR00to08load) begin
        ar_d[0:8] = left_src_s[0:8];
      end else begin
        ar_d[0:8] = ar_q[0:8];
      end

      if (CTL_AR00to11clr) begin
        ar_d[9:11] = 3'd0;
      end else if (CTL_AR09to17load) begin
        ar_d[9:11] = left_src_s[9:11];
      end else begin
        ar_d[9:11] = ar_q[9:11];
      end

      if (CTL_AR12to17clr) begin
        ar_d[12:17] = 6'd0;
      end else if (CTL_AR09to17load) begin
        ar_d[12:17] = left_src_s[12:17];
      end else begin
        ar_d[12:17] = ar_q[12:17];
      end

      if (CTL_ARRclr) begin
        ar_d[18:35] = 18'd0;
      end else if (CTL_ARRload) begin
        ar_d[18:35] = right_src_s;
      end else begin
        ar_d[18:35] = ar_q[18:35];
      end
    end
  end

  // ARX next state and sticky conflict
  always_comb begin
    arx_d      = arx_q;
    conflict_d = conflict_q;
    if (shift_en_s && ADlong) begin
      arx_d = {arx_q[1:35], ADXcarry36};
    end else if (CRAM_ARXload) begin
      arx_d = EDP_ADX;
    end else begin
      arx_d = arx_q;
    end
    if ((CRAM_ARshift && ar_strobe_s) || long_arx_collide_s) begin
      conflict_d = 1'b1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q       <= 36'd0;
      arx_q      <= 36'd0;
      carry36_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ar_q       <= ar_d;
      arx_q      <= arx_d;
      carry36_q  <= ADXcarry36;
      conflict_q <= conflict_d;
    end
  end

  assign EDP_AR          = ar_q;
  assign EDP_ARX         = arx_q;
  assign EDP_carry36Q    = carry36_q;
  assign EDP_ctlConflict = conflict_q;

endmodule

// File: tb/tb_edp_ar.sv
// Directed self-checking bench for edp_ar: field loads/clears, shifts, conflict, carry delay.
module tb_edp_ar;

  logic        clk;
  logic        reset;
  logic        CTL_ARL_SEL, CTL_ARR_SEL;
  logic        CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload;
  logic        CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr;
  logic        CRAM_ARXload, CRAM_ARshift, ADXcarry36, ADlong;
  logic [0:35] EDP_AD, EDP_ADX, MBOX_CACHE_DATA;
  logic [0:35] EDP_AR, EDP_ARX;
  logic        EDP_carry36Q, EDP_ctlConflict;

  int pass_cnt = 0;
  int total_cnt = 0;

  edp_ar dut (
    .clk              (clk),
    .reset            (reset),
    .CTL_ARL_SEL      (CTL_ARL_SEL),
    .CTL_ARR_SEL      (CTL_ARR_SEL),
    .CTL_AR00to08load (CTL_AR00to08load),
    .CTL_AR09to17load (CTL_AR09to17load),
    .CTL_ARRload      (CTL_ARRload),
    .CTL_AR00to11clr  (CTL_AR00to11clr),
    .CTL_AR12to17clr  (CTL_AR12to17clr),
    .CTL_ARRclr       (CTL_ARRclr),
    .CRAM_ARXload     (CRAM_ARXload),
    .CRAM_ARshift     (CRAM_ARshift),
    .ADXcarry36       (ADXcarry36),
    .ADlong           (ADlong),
    .EDP_AD           (EDP_AD),
    .EDP_ADX          (EDP_ADX),
    .MBOX_CACHE_DATA  (MBOX_CACHE_DATA),
    .EDP_AR           (EDP_AR),
    .EDP_ARX          (EDP_ARX),
    .EDP_carry36Q     (EDP_carry36Q),
    .EDP_ctlConflict  (EDP_ctlConflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0;
    CTL_ARL_SEL = 1'b0; CTL_ARR_SEL = 1'b0;
    CTL_AR00to08load = 1'b0; CTL_AR09to17load = 1'b0; CTL_ARRload = 1'b0;
    CTL_AR00to11clr = 1'b0; CTL_AR12to17clr = 1'b0; CTL_ARRclr = 1'b0;
    CRAM_ARXload = 1'b0; CRAM_ARshift = 1'b0; ADXcarry36 = 1'b0; ADlong = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    idle();
  endtask

  // Load whole AR from AD and ARX from ADX in one cycle
  task automatic preload(input logic [0:35] ar_v, input logic [0:35] arx_v);
    idle();
    EDP_AD = ar_v; EDP_ADX = arx_v;
    CTL_AR00to08load = 1'b1; CTL_AR09to17load = 1'b1; CTL_ARRload = 1'b1;
    CRAM_ARXload = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    EDP_AD = 36'o777777777777; EDP_ADX = 36'o777777777777;
    MBOX_CACHE_DATA = 36'o777777777777;
    CTL_AR00to08load = 1'b1; CTL_AR09to17load = 1'b1; CTL_ARRload = 1'b1;
    CRAM_ARXload = 1'b1; CRAM_ARshift = 1'b1; ADXcarry36 = 1'b1; ADlong = 1'b1;
    reset = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o0) $display("FAIL reset_ar: got %o expected %o", EDP_AR, 36'o0); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o0) $display("FAIL reset_arx: got %o expected %o", EDP_ARX, 36'o0); else pass_cnt++;
    total_cnt++; if (EDP_carry36Q !== 1'b0) $display("FAIL reset_carry: got %b expected 0", EDP_carry36Q); else pass_cnt++;
    total_cnt++; if (EDP_ctlConflict !== 1'b0) $display("FAIL reset_conflict: got %b expected 0", EDP_ctlConflict); else pass_cnt++;
    idle();
  endtask

  task automatic test_load();
    idle();
    EDP_AD = 36'o123456701234; EDP_ADX = 36'o765432101234;
    MBOX_CACHE_DATA = 36'o0;
    CTL_AR00to08load = 1'b1; CTL_AR09to17load = 1'b1; CTL_ARRload = 1'b1;
    CRAM_ARXload = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o123456701234) $display("FAIL load_ar: got %o expected %o", EDP_AR, 36'o123456701234); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o765432101234) $display("FAIL load_arx: got %o expected %o", EDP_ARX, 36'o765432101234); else pass_cnt++;
    idle();
    EDP_AD = 36'o0; EDP_ADX = 36'o0;
    step(); step(); step();
    total_cnt++; if (EDP_AR !== 36'o123456701234) $display("FAIL hold_ar: got %o expected %o", EDP_AR, 36'o123456701234); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o765432101234) $display("FAIL hold_arx: got %o expected %o", EDP_ARX, 36'o765432101234); else pass_cnt++;
    // Mixed sources: left from cache, right from AD
    idle();
    CTL_ARL_SEL = 1'b1; CTL_ARR_SEL = 1'b0;
    MBOX_CACHE_DATA = 36'o111111222222; EDP_AD = 36'o333333444444;
    CTL_AR00to08load = 1'b1; CTL_AR09to17load = 1'b1; CTL_ARRload = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o111111444444) $display("FAIL load_sel_mix: got %o expected %o", EDP_AR, 36'o111111444444); else pass_cnt++;
    idle();
  endtask

  task automatic test_fields();
    preload(36'o777777777777, 36'o0);
    CTL_ARL_SEL = 1'b1; MBOX_CACHE_DATA = 36'o0;
    CTL_AR00to11clr = 1'b1; CTL_AR09to17load = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o000000777777) $display("FAIL clr_left_cache0: got %o expected %o", EDP_AR, 36'o000000777777); else pass_cnt++;
    preload(36'o777777777777, 36'o0);
    CTL_ARL_SEL = 1'b1; MBOX_CACHE_DATA = 36'o777777777777;
    CTL_AR00to11clr = 1'b1; CTL_AR09to17load = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o000077777777) $display("FAIL clr_beats_load_f1: got %o expected %o", EDP_AR, 36'o000077777777); else pass_cnt++;
    idle();
    CTL_ARL_SEL = 1'b1; MBOX_CACHE_DATA = 36'o777777777777;
    CTL_AR12to17clr = 1'b1; CTL_AR09to17load = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o000700777777) $display("FAIL clr_beats_load_f2: got %o expected %o", EDP_AR, 36'o000700777777); else pass_cnt++;
    idle();
    EDP_AD = 36'o777777777777; CTL_AR00to08load = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o777700777777) $display("FAIL load_f0_only: got %o expected %o", EDP_AR, 36'o777700777777); else pass_cnt++;
    idle();
    EDP_AD = 36'o777777777777; CTL_ARRload = 1'b1; CTL_ARRclr = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o777700000000) $display("FAIL clr_beats_load_f3: got %o expected %o", EDP_AR, 36'o777700000000); else pass_cnt++;
    idle();
  endtask

  task automatic test_shift_short();
    preload(36'o400000000001, 36'o123123123123);
    CRAM_ARshift = 1'b1; ADlong = 1'b0; ADXcarry36 = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o000000000003) $display("FAIL shift_short_ar: got %o expected %o", EDP_AR, 36'o000000000003); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o123123123123) $display("FAIL shift_short_arx: got %o expected %o", EDP_ARX, 36'o123123123123); else pass_cnt++;
    total_cnt++; if (EDP_carry36Q !== 1'b1) $display("FAIL carry_delay_1: got %b expected 1", EDP_carry36Q); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (EDP_carry36Q !== 1'b0) $display("FAIL carry_delay_0: got %b expected 0", EDP_carry36Q); else pass_cnt++;
    total_cnt++; if (EDP_ctlConflict !== 1'b0) $display("FAIL no_conflict_shift: got %b expected 0", EDP_ctlConflict); else pass_cnt++;
  endtask

  task automatic test_shift_long();
    preload(36'o0, 36'o400000000000);
    CRAM_ARshift = 1'b1; ADlong = 1'b1; ADXcarry36 = 1'b0;
    step();
    total_cnt++; if (EDP_AR !== 36'o000000000001) $display("FAIL shift_long_ar: got %o expected %o", EDP_AR, 36'o000000000001); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o0) $display("FAIL shift_long_arx: got %o expected %o", EDP_ARX, 36'o0); else pass_cnt++;
    ADXcarry36 = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o000000000002) $display("FAIL shift_long2_ar: got %o expected %o", EDP_AR, 36'o000000000002); else pass_cnt++;
    total_cnt++; if (EDP_ARX !== 36'o000000000001) $display("FAIL shift_long2_arx: got %o expected %o", EDP_ARX, 36'o000000000001); else pass_cnt++;
    // Long shift wins over a same-cycle ARX load
    EDP_ADX = 36'o777777777777; CRAM_ARXload = 1'b1; ADXcarry36 = 1'b1;
    step();
    total_cnt++; if (EDP_ARX !== 36'o000000000003) $display("FAIL shift_beats_arxload: got %o expected %o", EDP_ARX, 36'o000000000003); else pass_cnt++;
    total_cnt++; if (EDP_AR !== 36'o000000000004) $display("FAIL shift_long3_ar: got %o expected %o", EDP_AR, 36'o000000000004); else pass_cnt++;
    idle();
  endtask

  task automatic test_conflict();
    do_reset();
    preload(36'o400000777777, 36'o0);
    CRAM_ARshift = 1'b1; CTL_ARRclr = 1'b1; ADXcarry36 = 1'b1;
    step();
    total_cnt++; if (EDP_AR !== 36'o400000000000) $display("FAIL conflict_ar: got %o expected %o", EDP_AR, 36'o400000000000); else pass_cnt++;
    total_cnt++; if (EDP_ctlConflict !== 1'b1) $display("FAIL conflict_set: got %b expected 1", EDP_ctlConflict); else pass_cnt++;
    idle();
    step(); step(); step();
    total_cnt++; if (EDP_ctlConflict !== 1'b1) $display("FAIL conflict_sticky: got %b expected 1", EDP_ctlConflict); else pass_cnt++;
    total_cnt++; if (EDP_AR !== 36'o400000000000) $display("FAIL conflict_hold_ar: got %o expected %o", EDP_AR, 36'o400000000000); else pass_cnt++;
    do_reset();
    total_cnt++; if (EDP_ctlConflict !== 1'b0) $display("FAIL conflict_cleared: got %b expected 0", EDP_ctlConflict); else pass_cnt++;
  endtask

  initial begin
    idle();
    EDP_AD = 36'o0; EDP_ADX = 36'o0; MBOX_CACHE_DATA = 36'o0;
    reset = 1'b1;
    step(); step();
    test_reset();
    test_load();
    test_fields();
    test_shift_short();
    test_shift_long();
    test_conflict();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
